// File: rtl/ntt_sdf_stage_ctrl.sv
// Sequencer for one radix-2 SDF NTT stage: counts streamed samples and drives
// butterfly/bypass select, delay-line shift, twiddle address and frame markers.
module ntt_sdf_stage_ctrl #(
    parameter int unsigned N         = 64,
    parameter int unsigned LOG2N     = 6,
    parameter int unsigned STAGE     = 0,
    parameter int unsigned TW_ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    output logic                 bf_mode,
    output logic                 dl_shift,
    output logic [TW_ADDR_W-1:0] tw_addr,
    output logic                 out_valid,
    output logic                 out_sop,
    output logic                 out_eop,
    output logic                 busy
);

    localparam int unsigned D  = N >> (STAGE + 1);
    localparam int unsigned CW = (LOG2N > STAGE) ? (LOG2N - STAGE) : 1;

    localparam logic [CW-1:0] CNT_D    = CW'(D);
    localparam logic [CW-1:0] CNT_DM1  = CW'(D - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(2 * D - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            flush_pend, flush_pend_nxt;
    logic            adv;
    logic [31:0]     tw_off;

    // State, sample counter and deferred-flush flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            flush_pend <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            flush_pend <= flush_pend_nxt;
        end
    end

    // Next state and handshake-qualified datapath controls
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        flush_pend_nxt = flush_pend;

        in_ready  = (state != DRAIN);
        adv       = (in_valid & in_ready) | (state == DRAIN);
        dl_shift  = adv;
        bf_mode   = (cnt >= CNT_D);
        tw_off    = 32'(cnt) - 32'(D);
        tw_addr   = bf_mode ? TW_ADDR_W'(tw_off << STAGE) : '0;
        out_valid = adv & ((state == RUN) | (state == DRAIN));
        out_sop   = out_valid & (cnt == CNT_D);
        out_eop   = out_valid & (cnt == CNT_DM1);
        busy      = (state != IDLE);

        if (adv) begin
            cnt_nxt = cnt + CW'(1);
        end

        case (state)
            IDLE: begin
                if (adv) begin
                    state_nxt = (D == 1) ? RUN : FILL;
                end
            end
            FILL: begin
                if (flush) begin
                    flush_pend_nxt = 1'b1;
                end
                if (adv && (cnt == CNT_DM1)) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    flush_pend_nxt = 1'b1;
                end
                // Drain is only entered on a frame boundary so no frame is split
                if (adv && (cnt == CNT_LAST) && (flush || flush_pend)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (cnt == CNT_DM1) begin
                    state_nxt      = IDLE;
                    cnt_nxt        = '0;
                    flush_pend_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ntt_sdf_stage_ctrl.sv
// Bench for ntt_sdf_stage_ctrl: three stage instances (D=32, 4, 1) checked
// against a sample-index model of the stream, fill, frame and drain behaviour.
module tb_ntt_sdf_stage_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] in_valid, flush;
    logic [2:0] in_ready, bf_mode, dl_shift, out_valid, out_sop, out_eop, busy;
    logic [4:0] tw0, tw1, tw2;

    int ncmp = 0;
    int nerr = 0;

    // Model: accepted samples since stream start, remaining drain cycles, pending flush
    int k[3];
    int dleft[3];
    bit fpend[3];

    always #5 clk = ~clk;

    ntt_sdf_stage_ctrl #(.N(64), .LOG2N(6), .STAGE(0), .TW_ADDR_W(5)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .flush(flush[0]), .bf_mode(bf_mode[0]), .dl_shift(dl_shift[0]), .tw_addr(tw0),
        .out_valid(out_valid[0]), .out_sop(out_sop[0]), .out_eop(out_eop[0]), .busy(busy[0]));

    ntt_sdf_stage_ctrl #(.N(64), .LOG2N(6), .STAGE(3), .TW_ADDR_W(5)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .flush(flush[1]), .bf_mode(bf_mode[1]), .dl_shift(dl_shift[1]), .tw_addr(tw1),
        .out_valid(out_valid[1]), .out_sop(out_sop[1]), .out_eop(out_eop[1]), .busy(busy[1]));

    ntt_sdf_stage_ctrl #(.N(64), .LOG2N(6), .STAGE(5), .TW_ADDR_W(5)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .flush(flush[2]), .bf_mode(bf_mode[2]), .dl_shift(dl_shift[2]), .tw_addr(tw2),
        .out_valid(out_valid[2]), .out_sop(out_sop[2]), .out_eop(out_eop[2]), .busy(busy[2]));

    function automatic int dof(input int i);
        case (i)
            0:       return 32;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic int sof(input int i);
        case (i)
            0:       return 0;
            1:       return 3;
            default: return 5;
        endcase
    endfunction

    function automatic logic [4:0] twof(input int i);
        case (i)
            0:       return tw0;
            1:       return tw1;
            default: return tw2;
        endcase
    endfunction

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s[u%0d] observed=%0d expected=%0d", tag, i, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            k[i] = 0;
            dleft[i] = 0;
            fpend[i] = 1'b0;
        end
    endtask

    task automatic check_reset_vals();
        for (int i = 0; i < 3; i++) begin
            chk("rst_in_ready", i, 32'(in_ready[i]), 1);
            chk("rst_out_valid", i, 32'(out_valid[i]), 0);
            chk("rst_out_sop", i, 32'(out_sop[i]), 0);
            chk("rst_out_eop", i, 32'(out_eop[i]), 0);
            chk("rst_bf_mode", i, 32'(bf_mode[i]), 0);
            chk("rst_dl_shift", i, 32'(dl_shift[i]), 0);
            chk("rst_tw_addr", i, 32'(twof(i)), 0);
            chk("rst_busy", i, 32'(busy[i]), 0);
        end
    endtask

    task automatic check_inst(input int i, input bit v);
        int d, m;
        bit e_rdy, e_sh, e_bf, e_ov, e_sop, e_eop, e_busy;
        int e_tw;
        d = dof(i);
        if (dleft[i] > 0) begin
            e_rdy = 0; e_sh = 1; e_bf = 0; e_tw = 0; e_ov = 1;
            e_sop = 0; e_eop = (dleft[i] == 1); e_busy = 1;
        end else begin
            m      = k[i] % (2 * d);
            e_rdy  = 1;
            e_sh   = v;
            e_bf   = (m >= d);
            e_tw   = e_bf ? (((m - d) * (1 << sof(i))) % 32) : 0;
            e_ov   = v && (k[i] >= d);
            e_sop  = e_ov && (m == d);
            e_eop  = e_ov && (m == d - 1);
            e_busy = (k[i] > 0);
        end
        chk("in_ready", i, 32'(in_ready[i]), 32'(e_rdy));
        chk("dl_shift", i, 32'(dl_shift[i]), 32'(e_sh));
        chk("bf_mode", i, 32'(bf_mode[i]), 32'(e_bf));
        chk("tw_addr", i, 32'(twof(i)), 32'(e_tw));
        chk("out_valid", i, 32'(out_valid[i]), 32'(e_ov));
        chk("out_sop", i, 32'(out_sop[i]), 32'(e_sop));
        chk("out_eop", i, 32'(out_eop[i]), 32'(e_eop));
        chk("busy", i, 32'(busy[i]), 32'(e_busy));
    endtask

    task automatic update_inst(input int i, input bit v, input bit f);
        int d, m;
        bit take;
        d = dof(i);
        if (dleft[i] > 0) begin
            dleft[i]--;
            if (dleft[i] == 0) begin
                k[i] = 0;
                fpend[i] = 1'b0;
            end
        end else begin
            m    = k[i] % (2 * d);
            take = v && (k[i] > 0) && (m == 2 * d - 1) && (fpend[i] || f);
            if (k[i] > 0 && f) fpend[i] = 1'b1;
            if (take) begin
                dleft[i] = d;
                k[i] = 0;
            end else if (v) begin
                k[i]++;
            end
        end
    endtask

    task automatic step(input bit [2:0] v, input bit [2:0] f);
        @(negedge clk);
        in_valid = v;
        flush    = f;
        #1;
        for (int i = 0; i < 3; i++) check_inst(i, v[i]);
        @(posedge clk);
        for (int i = 0; i < 3; i++) update_inst(i, v[i], f[i]);
    endtask

    task automatic async_reset();
        @(negedge clk);
        in_valid = '0;
        flush    = '0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Run every instance to its next frame boundary, drain it, and leave it idle
    task automatic drain_all();
        bit [2:0] v;
        for (int c = 0; c < 400; c++) begin
            if (k[0] == 0 && k[1] == 0 && k[2] == 0 &&
                dleft[0] == 0 && dleft[1] == 0 && dleft[2] == 0) break;
            for (int i = 0; i < 3; i++) v[i] = (dleft[i] == 0) && (k[i] > 0);
            step(v, 3'b111);
        end
    endtask

    initial begin
        bit [2:0] rv, rf;
        in_valid = '0;
        flush    = '0;
        rst_n    = 1'b0;
        model_clear();
        #3;
        check_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;

        // Continuous stream, flush pulsed at sample 10 of frame 3 for the D=32 stage
        for (int c = 0; c < 240; c++) step(3'b111, (c == 138) ? 3'b111 : 3'b000);
        drain_all();

        // Random valid gaps with occasional flush pulses
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) begin
                rv[i] = 1'($urandom % 2);
                rf[i] = ($urandom_range(0, 39) == 0);
            end
            step(rv, rf);
        end
        drain_all();

        // Flush while idle must not start anything
        repeat (4) step(3'b000, 3'b111);

        // Asynchronous reset in RUN at cnt=40, then the fill must repeat
        for (int c = 0; c < 40; c++) step(3'b001, 3'b000);
        async_reset();
        for (int c = 0; c < 40; c++) step(3'b111, 3'b000);
        drain_all();

        // Flush coincident with the last sample of a frame
        for (int c = 0; c < 64; c++) step(3'b001, (c == 63) ? 3'b001 : 3'b000);
        step(3'b001, 3'b000);
        drain_all();
        step(3'b000, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
